// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a byte stream three bytes per word and writes
// the words to consecutive addresses from 0, holding the core off while loading.
module imem_loader #(
    parameter int DATA_WIDTH    = 20,
    parameter int ADDRESS_WIDTH = 8,
    parameter int MEM_SIZE      = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH:0]   length,
    input  logic                     byte_valid,
    input  logic [7:0]               byte_data,
    output logic                     byte_ready,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    output logic                     core_hold,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [DATA_WIDTH-1:0]    checksum
);

    localparam int CNT_WIDTH = ADDRESS_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] MEM_SIZE_C = CNT_WIDTH'(MEM_SIZE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  state_reg;
    logic [CNT_WIDTH-1:0]    len_reg;
    logic [CNT_WIDTH-1:0]    word_cnt_reg;
    logic [1:0]              byte_idx_reg;
    logic [15:0]             lo_bytes_reg;
    logic                    byte_ready_reg;
    logic                    mem_we_reg;
    logic [ADDRESS_WIDTH-1:0] mem_addr_reg;
    logic [DATA_WIDTH-1:0]   mem_wdata_reg;
    logic                    busy_reg;
    logic                    done_reg;
    logic                    error_reg;
    logic [DATA_WIDTH-1:0]   checksum_reg;

    // Third byte supplies only the bits above the first two bytes (nibble for 20-bit words).
    logic [DATA_WIDTH-1:0]   full_word;
    logic [CNT_WIDTH-1:0]    word_cnt_next;

    assign full_word     = {byte_data[DATA_WIDTH-17:0], lo_bytes_reg};
    assign word_cnt_next = word_cnt_reg + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= S_IDLE;
            len_reg        <= '0;
            word_cnt_reg   <= '0;
            byte_idx_reg   <= '0;
            lo_bytes_reg   <= '0;
            byte_ready_reg <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            error_reg      <= 1'b0;
            checksum_reg   <= '0;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        len_reg      <= length;
                        word_cnt_reg <= '0;
                        byte_idx_reg <= '0;
                        checksum_reg <= '0;
                        done_reg     <= 1'b0;
                        error_reg    <= 1'b0;
                        if (length == '0) begin
                            state_reg <= S_DONE;
                            done_reg  <= 1'b1;
                        end else if (length > MEM_SIZE_C) begin
                            state_reg <= S_DONE;
                            done_reg  <= 1'b1;
                            error_reg <= 1'b1;
                        end else begin
                            state_reg      <= S_RECV;
                            byte_ready_reg <= 1'b1;
                            busy_reg       <= 1'b1;
                        end
                    end
                end

                S_RECV: begin
                    if (byte_valid && byte_ready_reg) begin
                        case (byte_idx_reg)
                            2'd0: begin
                                lo_bytes_reg[7:0] <= byte_data;
                                byte_idx_reg      <= 2'd1;
                            end
                            2'd1: begin
                                lo_bytes_reg[15:8] <= byte_data;
                                byte_idx_reg       <= 2'd2;
                            end
                            default: begin
                                // Word complete: present it to memory during the WRITE cycle.
                                byte_idx_reg   <= 2'd0;
                                mem_we_reg     <= 1'b1;
                                mem_addr_reg   <= word_cnt_reg[ADDRESS_WIDTH-1:0];
                                mem_wdata_reg  <= full_word;
                                byte_ready_reg <= 1'b0;
                                state_reg      <= S_WRITE;
                            end
                        endcase
                    end
                end

                S_WRITE: begin
                    mem_we_reg   <= 1'b0;
                    checksum_reg <= checksum_reg ^ mem_wdata_reg;
                    word_cnt_reg <= word_cnt_next;
                    if (word_cnt_next == len_reg) begin
                        state_reg <= S_DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        state_reg      <= S_RECV;
                        byte_ready_reg <= 1'b1;
                    end
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign byte_ready = byte_ready_reg;
    assign mem_we     = mem_we_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign busy       = busy_reg;
    assign core_hold  = busy_reg;
    assign done       = done_reg;
    assign error      = error_reg;
    assign checksum   = checksum_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a write scoreboard fed from the bytes sent, plus
// literal expectations for the documented example load.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [8:0]  length = '0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [19:0] mem_wdata;
    logic        core_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [19:0] checksum;

    imem_loader #(.DATA_WIDTH(20), .ADDRESS_WIDTH(8), .MEM_SIZE(256)) dut (
        .clk(clk), .rst(rst), .start(start), .length(length),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_hold(core_hold), .busy(busy), .done(done), .error(error),
        .checksum(checksum)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          wr_cnt = 0;
    int          s_cyc;
    logic [19:0] wr_log [0:511];
    logic [27:0] exp_q [$];
    logic [19:0] exp_ck = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Every cycle out of reset: core_hold mirrors busy, and each write must match the
    // oldest word whose third byte has already been handed over.
    always @(negedge clk) begin
        if (rst) begin
            n_cmp++;
            if (core_hold !== busy) begin
                n_fail++;
                $display("FAIL hold_vs_busy: core_hold=%b busy=%b", core_hold, busy);
            end
            if (mem_we) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write: addr=%0d data=0x%h, required no write", mem_addr, mem_wdata);
                end else begin
                    logic [27:0] e;
                    e = exp_q.pop_front();
                    if ({mem_addr, mem_wdata} !== e) begin
                        n_fail++;
                        $display("FAIL write: addr=%0d data=0x%h, required addr=%0d data=0x%h",
                                 mem_addr, mem_wdata, e[27:20], e[19:0]);
                    end
                    wr_log[wr_cnt] = mem_wdata;
                    wr_cnt++;
                end
            end
        end
    end

    function automatic logic [19:0] pack(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        return 20'(b0) + (20'(b1) << 8) + (20'(b2 & 8'h0F) << 16);
    endfunction

    // Called at a negedge; returns at the negedge after the start edge.
    task automatic pulse_start(input logic [8:0] len);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        exp_ck = '0;
        wr_cnt = 0;
        start  = 1'b1;
        length = len;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        s_cyc = cyc;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit push, input logic [27:0] entry);
        bit ok;
        ok = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        for (int t = 0; t < 40; t++) begin
            if (byte_ready) begin
                @(posedge clk);
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (push && ok) exp_q.push_back(entry);
        @(negedge clk);
        byte_valid = 1'b0;
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL byte_timeout: byte 0x%h not accepted, required byte_ready within 40 cycles", b);
        end
    endtask

    task automatic send_word(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input int addr, input bit gap);
        logic [19:0] w;
        w = pack(b0, b1, b2);
        if (gap) @(negedge clk);
        send_byte(b0, 0, '0);
        if (gap) @(negedge clk);
        send_byte(b1, 0, '0);
        if (gap) @(negedge clk);
        send_byte(b2, 1, {addr[7:0], w});
        exp_ck = exp_ck ^ w;
    endtask

    // At the negedge after the final third-byte edge: WRITE cycle, then release.
    task automatic end_load_check(input string tag);
        chk({tag, "_we_last"}, 32'(mem_we), 32'd1);
        chk({tag, "_hold_in_write"}, 32'(core_hold), 32'd1);
        @(negedge clk);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_hold_released"}, 32'(core_hold), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_checksum"}, 32'(checksum), 32'(exp_ck));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_outputs"},
            {byte_ready, mem_we, core_hold, busy, done, error, 26'd0},
            32'd0);
        chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_checksum"}, 32'(checksum), 32'd0);
    endtask

    initial begin
        #1;
        check_all_zero("reset");
        #12;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Example load of two words, source always valid.
        pulse_start(9'd2);
        chk("ex_ready_after_start", 32'(byte_ready), 32'd1);
        chk("ex_busy_after_start", 32'(busy), 32'd1);
        send_word(8'h34, 8'h12, 8'h05, 0, 0);
        send_word(8'hCD, 8'hAB, 8'hF7, 1, 0);
        end_load_check("ex");
        chk("ex_checksum_lit", 32'(checksum), 32'h2B9F9);
        chk("ex_word0_lit", 32'(wr_log[0]), 32'h51234);
        chk("ex_word1_lit", 32'(wr_log[1]), 32'h7ABCD);
        chk("ex_cycles", 32'(cyc - s_cyc), 32'd8);

        // Zero length: immediate done, nothing written.
        pulse_start(9'd0);
        chk("len0_done", 32'(done), 32'd1);
        chk("len0_error", 32'(error), 32'd0);
        chk("len0_busy", 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
        chk("len0_writes", 32'(wr_cnt), 32'd0);

        // Oversize: rejected with error.
        pulse_start(9'd257);
        chk("len257_done", 32'(done), 32'd1);
        chk("len257_error", 32'(error), 32'd1);
        chk("len257_busy", 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
        chk("len257_writes", 32'(wr_cnt), 32'd0);

        // Restart from DONE with a throttled source.
        pulse_start(9'd2);
        chk("thr_done_cleared", 32'(done), 32'd0);
        chk("thr_error_cleared", 32'(error), 32'd0);
        chk("thr_checksum_cleared", 32'(checksum), 32'd0);
        send_word(8'h34, 8'h12, 8'h05, 0, 1);
        send_word(8'hCD, 8'hAB, 8'hF7, 1, 1);
        end_load_check("thr");
        chk("thr_checksum_lit", 32'(checksum), 32'h2B9F9);
        chk("thr_writes", 32'(wr_cnt), 32'd2);

        // Full memory.
        pulse_start(9'd256);
        for (int i = 0; i < 256; i++) begin
            logic [7:0] iv;
            iv = 8'(i);
            send_word(iv, ~iv, 8'(i * 3), i, 0);
        end
        end_load_check("full");
        chk("full_writes", 32'(wr_cnt), 32'd256);
        chk("full_last_addr", 32'(mem_addr), 32'd255);

        // Start pulsed mid-load is ignored.
        pulse_start(9'd3);
        send_byte(8'hA1, 0, '0);
        start  = 1'b1;
        length = 9'd1;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'hB2, 0, '0);
        send_byte(8'hC3, 1, {8'd0, pack(8'hA1, 8'hB2, 8'hC3)});
        exp_ck = pack(8'hA1, 8'hB2, 8'hC3);
        send_word(8'h01, 8'h02, 8'h03, 1, 0);
        send_word(8'hFF, 8'hEE, 8'hDD, 2, 0);
        end_load_check("ign");
        chk("ign_writes", 32'(wr_cnt), 32'd3);

        // Reset in the middle of a load.
        pulse_start(9'd2);
        send_byte(8'h55, 0, '0);
        send_byte(8'h66, 0, '0);
        byte_valid = 1'b1;
        byte_data  = 8'h77;
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("midrst_ready", 32'(byte_ready), 32'd0);
        chk("midrst_idle", {30'd0, busy, done}, 32'd0);
        chk("midrst_writes", 32'(wr_cnt), 32'd0);
        byte_valid = 1'b0;

        // Fresh load after reset starts at address 0.
        pulse_start(9'd1);
        chk("post_done_low", 32'(done), 32'd0);
        send_word(8'h11, 8'h22, 8'h3F, 0, 0);
        end_load_check("post");
        chk("post_word_lit", 32'(wr_log[0]), 32'hF2211);
        chk("post_queue", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 2 ms");
        $fatal(1, "timeout");
    end

endmodule
